// File: rtl/pmu_seq.sv
// Power-up sequencer and rail supervisor for the analog PMU macro.
// Sequences bias/POC/regulator/detector enables, enforces step timeouts, filters comparator faults.
module pmu_seq #(
    parameter int unsigned      TMO_W   = 16,
    parameter logic [TMO_W-1:0] BG_TMO  = 16'd4000,
    parameter logic [TMO_W-1:0] RDY_TMO = 16'd2000,
    parameter logic [TMO_W-1:0] SETTLE  = 16'd64,
    parameter logic [3:0]       FILT    = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       sleep_i,
    input  logic       clear_i,
    input  logic       bgrdy_a,
    input  logic       vr85ardy_a,
    input  logic       vr85drdy_a,
    input  logic       vr25rdy_a,
    input  logic       por_a,
    input  logic [5:0] vd_a,
    output logic       ibiasena_o,
    output logic       pocena_o,
    output logic       vr85aena_o,
    output logic       vr85dena_o,
    output logic       vr25ena_o,
    output logic [2:0] vdena_o,
    output logic       pwr_good_o,
    output logic       fault_o,
    output logic [2:0] fault_code_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_WAIT_BG   = 4'd1,
        S_RAMP_85A  = 4'd2,
        S_RAMP_85D  = 4'd3,
        S_RAMP_25   = 4'd4,
        S_VD_SETTLE = 4'd5,
        S_ACTIVE    = 4'd6,
        S_SLEEP     = 4'd7,
        S_FAULT     = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE = 3'd0,
        FC_BG   = 3'd1,
        FC_85A  = 3'd2,
        FC_85D  = 3'd3,
        FC_25   = 3'd4,
        FC_VD   = 3'd5
    } fault_t;

    state_t            state_q, state_d;
    fault_t            code_q, code_d;
    logic              fault_q, fault_d;
    logic [TMO_W-1:0]  tmo_q;
    logic [3:0]        filt_q;
    logic [10:0]       sync1_q, sync2_q;

    logic              bgrdy_s, vr85ardy_s, vr85drdy_s, vr25rdy_s, por_s;
    logic [5:0]        vd_s;
    logic              vd_ok, tmo_last, filt_trip;

    // Two-flop synchronizers for all asynchronous PMU status
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {por_a, vr25rdy_a, vr85drdy_a, vr85ardy_a, bgrdy_a, vd_a};
            sync2_q <= sync1_q;
        end
    end

    assign {por_s, vr25rdy_s, vr85drdy_s, vr85ardy_s, bgrdy_s, vd_s} = sync2_q;
    assign vd_ok = &vd_s;

    // Counter hits 0 on the coming edge, so decisions taken now land exactly at expiry
    assign tmo_last  = (tmo_q <= TMO_W'(1));
    assign filt_trip = (state_q == S_ACTIVE) && !vd_ok &&
                       (({1'b0, filt_q} + 5'd1) >= {1'b0, FILT});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            code_q  <= FC_NONE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (state_d != state_q) begin
            case (state_d)
                S_WAIT_BG:                          tmo_q <= BG_TMO;
                S_RAMP_85A, S_RAMP_85D, S_RAMP_25:  tmo_q <= RDY_TMO;
                S_VD_SETTLE:                        tmo_q <= SETTLE;
                default:                            tmo_q <= '0;
            endcase
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q != S_ACTIVE || vd_ok) begin
            filt_q <= '0;
        end else if (filt_q != '1) begin
            filt_q <= filt_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        fault_d = fault_q;
        case (state_q)
            S_OFF: begin
                if (start_i) state_d = S_WAIT_BG;
            end
            S_WAIT_BG: begin
                if (bgrdy_s) begin
                    state_d = S_RAMP_85A;
                end else if (tmo_last) begin
                    state_d = S_FAULT;
                    code_d  = FC_BG;
                    fault_d = 1'b1;
                end
            end
            S_RAMP_85A: begin
                if (vr85ardy_s) begin
                    state_d = S_RAMP_85D;
                end else if (tmo_last) begin
                    state_d = S_FAULT;
                    code_d  = FC_85A;
                    fault_d = 1'b1;
                end
            end
            S_RAMP_85D: begin
                if (vr85drdy_s) begin
                    state_d = S_RAMP_25;
                end else if (tmo_last) begin
                    state_d = S_FAULT;
                    code_d  = FC_85D;
                    fault_d = 1'b1;
                end
            end
            S_RAMP_25: begin
                if (vr25rdy_s) begin
                    state_d = S_VD_SETTLE;
                end else if (tmo_last) begin
                    state_d = S_FAULT;
                    code_d  = FC_25;
                    fault_d = 1'b1;
                end
            end
            S_VD_SETTLE: begin
                if (tmo_last) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (filt_trip) begin
                    state_d = S_FAULT;
                    code_d  = FC_VD;
                    fault_d = 1'b1;
                end else if (!start_i) begin
                    state_d = S_OFF;
                end else if (sleep_i) begin
                    state_d = S_SLEEP;
                end
            end
            S_SLEEP: begin
                if (!start_i) begin
                    state_d = S_OFF;
                end else if (!sleep_i) begin
                    state_d = S_RAMP_85D;
                end
            end
            S_FAULT: begin
                if (clear_i) begin
                    state_d = S_OFF;
                    code_d  = FC_NONE;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // POR overrides everything outside FAULT and never records a fault
        if (por_s && state_q != S_FAULT) begin
            state_d = S_OFF;
            code_d  = code_q;
            fault_d = fault_q;
        end
    end

    always_comb begin
        ibiasena_o = 1'b0;
        pocena_o   = 1'b0;
        vr85aena_o = 1'b0;
        vr85dena_o = 1'b0;
        vr25ena_o  = 1'b0;
        vdena_o    = '0;
        pwr_good_o = 1'b0;
        case (state_q)
            S_RAMP_85A, S_SLEEP: begin
                {ibiasena_o, pocena_o, vr85aena_o} = 3'b111;
            end
            S_RAMP_85D: begin
                {ibiasena_o, pocena_o, vr85aena_o, vr85dena_o} = 4'b1111;
            end
            S_RAMP_25: begin
                {ibiasena_o, pocena_o, vr85aena_o, vr85dena_o, vr25ena_o} = 5'b11111;
            end
            S_VD_SETTLE: begin
                {ibiasena_o, pocena_o, vr85aena_o, vr85dena_o, vr25ena_o} = 5'b11111;
                vdena_o = '1;
            end
            S_ACTIVE: begin
                {ibiasena_o, pocena_o, vr85aena_o, vr85dena_o, vr25ena_o} = 5'b11111;
                vdena_o    = '1;
                pwr_good_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o      = state_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;

endmodule

// File: tb/tb_pmu_seq.sv
// Directed bench for pmu_seq: vector table for the nominal flow plus hand sequences
// for timeout boundaries, late/early readies and mid-sequence reset.
module tb_pmu_seq;

    localparam int unsigned BG_CYC  = 40;
    localparam int unsigned RDY_CYC = 30;
    localparam int unsigned SET_CYC = 16;

    localparam logic [7:0] EN_0  = 8'b00000_000;
    localparam logic [7:0] EN_A  = 8'b11100_000;
    localparam logic [7:0] EN_D  = 8'b11110_000;
    localparam logic [7:0] EN_25 = 8'b11111_000;
    localparam logic [7:0] EN_VD = 8'b11111_111;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, sleep_i, clear_i;
    logic       bgrdy_a, vr85ardy_a, vr85drdy_a, vr25rdy_a, por_a;
    logic [5:0] vd_a;
    logic       ibiasena_o, pocena_o, vr85aena_o, vr85dena_o, vr25ena_o;
    logic [2:0] vdena_o;
    logic       pwr_good_o, fault_o;
    logic [2:0] fault_code_o;
    logic [3:0] state_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        string       name;
        logic        start;
        logic        sleep;
        logic        clear;
        logic [4:0]  pmu;    // {por, vr25, vr85d, vr85a, bg}
        logic [5:0]  vd;
        int unsigned hold;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];

    pmu_seq #(
        .TMO_W  (16),
        .BG_TMO (16'(BG_CYC)),
        .RDY_TMO(16'(RDY_CYC)),
        .SETTLE (16'(SET_CYC)),
        .FILT   (4'd8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .sleep_i     (sleep_i),
        .clear_i     (clear_i),
        .bgrdy_a     (bgrdy_a),
        .vr85ardy_a  (vr85ardy_a),
        .vr85drdy_a  (vr85drdy_a),
        .vr25rdy_a   (vr25rdy_a),
        .por_a       (por_a),
        .vd_a        (vd_a),
        .ibiasena_o  (ibiasena_o),
        .pocena_o    (pocena_o),
        .vr85aena_o  (vr85aena_o),
        .vr85dena_o  (vr85dena_o),
        .vr25ena_o   (vr25ena_o),
        .vdena_o     (vdena_o),
        .pwr_good_o  (pwr_good_o),
        .fault_o     (fault_o),
        .fault_code_o(fault_code_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [3:0] st, input logic [7:0] en,
                                       input logic pg, input logic f, input logic [2:0] c);
        return {st, en, pg, f, c};
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] got;
        got = {state_o, ibiasena_o, pocena_o, vr85aena_o, vr85dena_o, vr25ena_o,
               vdena_o, pwr_good_o, fault_o, fault_code_o};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got state=%0d en=%b pg=%b fault=%b code=%0d, want state=%0d en=%b pg=%b fault=%b code=%0d",
                     name, got[16:13], got[12:5], got[4], got[3], got[2:0],
                     exp[16:13], exp[12:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic wait_state(input string name, input logic [3:0] target, input int unsigned budget);
        int unsigned cnt;
        cnt = 0;
        while (state_o !== target && cnt < budget) begin
            tick(1);
            cnt++;
        end
        n_vec++;
        if (state_o !== target) begin
            n_err++;
            $display("FAIL %s: state=%0d after %0d cycles, want state=%0d", name, state_o, cnt, target);
        end
    endtask

    task automatic set_pmu(input logic [4:0] p);
        {por_a, vr25rdy_a, vr85drdy_a, vr85ardy_a, bgrdy_a} = p;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start_i = 1'b0;
        sleep_i = 1'b0;
        clear_i = 1'b0;
        set_pmu(5'b00000);
        vd_a    = 6'h3F;
        tick(1);
        rst     = 1'b0;
    endtask

    task automatic add(input string n, input logic s, input logic sl, input logic c,
                       input logic [4:0] p, input logic [5:0] v, input int unsigned h,
                       input logic [16:0] e);
        vec_t r;
        r.name = n; r.start = s; r.sleep = sl; r.clear = c;
        r.pmu = p; r.vd = v; r.hold = h; r.exp = e;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add("start",      1, 0, 0, 5'b00000, 6'h3F, 1,         mk(4'd1, EN_0,  0, 0, 0));
        add("wait_bg",    1, 0, 0, 5'b00000, 6'h3F, 9,         mk(4'd1, EN_0,  0, 0, 0));
        add("bg_sync",    1, 0, 0, 5'b00001, 6'h3F, 2,         mk(4'd1, EN_0,  0, 0, 0));
        add("en_85a",     1, 0, 0, 5'b00001, 6'h3F, 1,         mk(4'd2, EN_A,  0, 0, 0));
        add("hold_85a",   1, 0, 0, 5'b00001, 6'h3F, 10,        mk(4'd2, EN_A,  0, 0, 0));
        add("sync_85a",   1, 0, 0, 5'b00011, 6'h3F, 2,         mk(4'd2, EN_A,  0, 0, 0));
        add("en_85d",     1, 0, 0, 5'b00011, 6'h3F, 1,         mk(4'd3, EN_D,  0, 0, 0));
        add("hold_85d",   1, 0, 0, 5'b00011, 6'h3F, 10,        mk(4'd3, EN_D,  0, 0, 0));
        add("en_25",      1, 0, 0, 5'b00111, 6'h3F, 3,         mk(4'd4, EN_25, 0, 0, 0));
        add("hold_25",    1, 0, 0, 5'b00111, 6'h3F, 10,        mk(4'd4, EN_25, 0, 0, 0));
        add("en_vd",      1, 0, 0, 5'b01111, 6'h3F, 3,         mk(4'd5, EN_VD, 0, 0, 0));
        add("settle",     1, 0, 0, 5'b01111, 6'h3F, SET_CYC-1, mk(4'd5, EN_VD, 0, 0, 0));
        add("active",     1, 0, 0, 5'b01111, 6'h3F, 1,         mk(4'd6, EN_VD, 1, 0, 0));
        add("vd_dip7",    1, 0, 0, 5'b01111, 6'h3E, 7,         mk(4'd6, EN_VD, 1, 0, 0));
        add("vd_back",    1, 0, 0, 5'b01111, 6'h3F, 12,        mk(4'd6, EN_VD, 1, 0, 0));
        add("vd_dip8",    1, 0, 0, 5'b01111, 6'h3E, 8,         mk(4'd6, EN_VD, 1, 0, 0));
        add("vd_fault",   1, 0, 0, 5'b01111, 6'h3F, 2,         mk(4'd8, EN_0,  0, 1, 5));
        add("fault_hold", 1, 0, 0, 5'b01111, 6'h3F, 5,         mk(4'd8, EN_0,  0, 1, 5));
        add("clear",      1, 0, 1, 5'b01111, 6'h3F, 1,         mk(4'd0, EN_0,  0, 0, 0));
        add("restart",    1, 0, 0, 5'b01111, 6'h3F, 1,         mk(4'd1, EN_0,  0, 0, 0));
        add("reramp",     1, 0, 0, 5'b01111, 6'h3F, 4,         mk(4'd5, EN_VD, 0, 0, 0));
        add("reactive",   1, 0, 0, 5'b01111, 6'h3F, SET_CYC,   mk(4'd6, EN_VD, 1, 0, 0));
        add("sleep",      1, 1, 0, 5'b01111, 6'h3F, 1,         mk(4'd7, EN_A,  0, 0, 0));
        add("sleep_hold", 1, 1, 0, 5'b01111, 6'h3F, 5,         mk(4'd7, EN_A,  0, 0, 0));
        add("wake_85d",   1, 0, 0, 5'b01111, 6'h3F, 1,         mk(4'd3, EN_D,  0, 0, 0));
        add("wake_25",    1, 0, 0, 5'b01111, 6'h3F, 1,         mk(4'd4, EN_25, 0, 0, 0));
        add("wake_vd",    1, 0, 0, 5'b01111, 6'h3F, 1,         mk(4'd5, EN_VD, 0, 0, 0));
        add("wake_act",   1, 0, 0, 5'b01111, 6'h3F, SET_CYC,   mk(4'd6, EN_VD, 1, 0, 0));
        add("sleep2",     1, 1, 0, 5'b01111, 6'h3F, 1,         mk(4'd7, EN_A,  0, 0, 0));
        add("sleep_off",  0, 0, 0, 5'b01111, 6'h3F, 1,         mk(4'd0, EN_0,  0, 0, 0));
        add("to_ramp25",  1, 0, 0, 5'b00111, 6'h3F, 4,         mk(4'd4, EN_25, 0, 0, 0));
        add("por_sync",   1, 0, 0, 5'b10111, 6'h3F, 2,         mk(4'd4, EN_25, 0, 0, 0));
        add("por_off",    1, 0, 0, 5'b10111, 6'h3F, 1,         mk(4'd0, EN_0,  0, 0, 0));
        add("por_hold",   1, 0, 0, 5'b10111, 6'h3F, 3,         mk(4'd0, EN_0,  0, 0, 0));
        add("por_rel",    1, 0, 0, 5'b00111, 6'h3F, 2,         mk(4'd0, EN_0,  0, 0, 0));
        add("por_start",  1, 0, 0, 5'b00111, 6'h3F, 1,         mk(4'd1, EN_0,  0, 0, 0));

        do_reset();
        tick(1);
        check("reset", mk(4'd0, EN_0, 0, 0, 0));

        foreach (tbl[i]) begin
            start_i = tbl[i].start;
            sleep_i = tbl[i].sleep;
            clear_i = tbl[i].clear;
            set_pmu(tbl[i].pmu);
            vd_a    = tbl[i].vd;
            tick(tbl[i].hold);
            check(tbl[i].name, tbl[i].exp);
        end

        // BG timeout and clear
        do_reset();
        start_i = 1'b1;
        tick(1);
        check("bgt_entry", mk(4'd1, EN_0, 0, 0, 0));
        tick(BG_CYC - 1);
        check("bgt_last", mk(4'd1, EN_0, 0, 0, 0));
        tick(1);
        check("bgt_fault", mk(4'd8, EN_0, 0, 1, 1));
        start_i = 1'b0;
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        check("bgt_clear", mk(4'd0, EN_0, 0, 0, 0));

        // VR85A ready lands on the final timeout cycle: advance
        do_reset();
        start_i = 1'b1;
        set_pmu(5'b00001);
        wait_state("last_enter", 4'd2, 20);
        tick(RDY_CYC - 3);
        set_pmu(5'b00011);
        tick(2);
        check("last_hold", mk(4'd2, EN_A, 0, 0, 0));
        tick(1);
        check("last_adv", mk(4'd3, EN_D, 0, 0, 0));

        // VR85A ready one cycle too late: fault code 2
        do_reset();
        start_i = 1'b1;
        set_pmu(5'b00001);
        wait_state("late_enter", 4'd2, 20);
        tick(RDY_CYC - 2);
        set_pmu(5'b00011);
        tick(2);
        check("late_fault", mk(4'd8, EN_0, 0, 1, 2));

        // VR85D timeout
        do_reset();
        start_i = 1'b1;
        set_pmu(5'b00011);
        wait_state("t85d_enter", 4'd3, 20);
        tick(RDY_CYC);
        check("t85d_fault", mk(4'd8, EN_0, 0, 1, 3));

        // VR25 timeout
        do_reset();
        start_i = 1'b1;
        set_pmu(5'b00111);
        wait_state("t25_enter", 4'd4, 20);
        tick(RDY_CYC - 1);
        check("t25_last", mk(4'd4, EN_25, 0, 0, 0));
        tick(1);
        check("t25_fault", mk(4'd8, EN_0, 0, 1, 4));

        // ACTIVE drops to OFF when start is released; reset mid-ramp clears all
        do_reset();
        start_i = 1'b1;
        set_pmu(5'b01111);
        wait_state("act_enter", 4'd6, 100);
        start_i = 1'b0;
        tick(1);
        check("act_off", mk(4'd0, EN_0, 0, 0, 0));
        start_i = 1'b1;
        wait_state("rst_enter", 4'd5, 20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid", mk(4'd0, EN_0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
